// File: rtl/fsb8_target.sv
// FSB 8-bit target endpoint: decodes address/command/read/write frames into single-beat local requests.
// Registered response 2 cycles after the frame at best, plus one per loc_ack wait cycle; host is paced by rdy_n.
module fsb8_target #(
  parameter bit PAE_ENABLE = 1'b0,
  parameter int ADDR_WIDTH = PAE_ENABLE ? 32 : 24,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ale_n,
  input  logic                  cs_n,
  input  logic                  cmd_n,
  input  logic                  wr_n,
  input  logic                  typ,
  input  logic [7:0]            AAH8,
  input  logic [7:0]            AD_in,
  output logic [7:0]            AD_out,
  output logic                  AD_oe,
  output logic                  rdy_n,
  output logic                  irq_n,
  output logic [ADDR_WIDTH-1:0] loc_addr,
  output logic [7:0]            loc_wdata,
  output logic                  loc_re,
  output logic                  loc_we,
  input  logic [7:0]            loc_rdata,
  input  logic                  loc_ack,
  input  logic [7:0]            irq_src,
  output logic                  bus_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state;
  logic [7:0]  h8;
  logic [15:0] m16;
  logic [7:0]  l8;
  logic [7:0]  rd_reg;
  logic [7:0]  wait_cnt;
  logic [7:0]  irq_mask;
  logic [7:0]  irq_pend;
  logic [7:0]  irq_src_q;
  logic        idle;
  logic        cmd_clr;
  logic        timeout;
  logic [7:0]  irq_rise;
  logic [7:0]  clr_mask;

  assign idle     = (state == IDLE);
  assign cmd_clr  = idle && ale_n && !cmd_n && (AD_in == 8'h02);
  assign clr_mask = cmd_clr ? AAH8 : 8'h00;
  assign irq_rise = irq_src & ~irq_src_q;
  assign timeout  = (wait_cnt == 8'(WAIT_LIMIT - 1));
  assign AD_out   = rd_reg;

  // Without the address extension H8 is never loaded and drops out of the local address.
  generate
    if (PAE_ENABLE) begin : g_pae
      logic unused_typ;
      assign unused_typ = typ;
      assign loc_addr   = {h8, m16, l8};
    end else begin : g_nopae
      logic unused_bits;
      assign unused_bits = typ ^ (^h8);
      assign loc_addr    = {m16, l8};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      h8        <= 8'h00;
      m16       <= 16'h0000;
      l8        <= 8'h00;
      rd_reg    <= 8'h00;
      wait_cnt  <= 8'h00;
      irq_mask  <= 8'h00;
      irq_pend  <= 8'h00;
      irq_src_q <= 8'h00;
      irq_n     <= 1'b1;
      rdy_n     <= 1'b1;
      AD_oe     <= 1'b0;
      loc_wdata <= 8'h00;
      loc_re    <= 1'b0;
      loc_we    <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      loc_re    <= 1'b0;
      loc_we    <= 1'b0;
      bus_err   <= 1'b0;
      rdy_n     <= 1'b1;
      AD_oe     <= 1'b0;
      irq_src_q <= irq_src;
      // A new edge wins over a same-cycle W1C clear.
      irq_pend  <= (irq_pend & ~clr_mask) | irq_rise;
      irq_n     <= ~|(irq_pend & irq_mask);

      case (state)
        IDLE: begin
          if (!ale_n) begin
            m16 <= {AAH8, AD_in};
          end else if (!cmd_n) begin
            case (AD_in)
              8'h00:   if (PAE_ENABLE) h8 <= AAH8;
              8'h01:   irq_mask <= AAH8;
              8'h02:   ;
              default: bus_err <= 1'b1;
            endcase
          end else if (!cs_n) begin
            l8       <= AAH8;
            wait_cnt <= 8'h00;
            if (wr_n) begin
              state  <= RD_REQ;
              loc_re <= 1'b1;
            end else begin
              loc_wdata <= AD_in;
              state     <= WR_REQ;
              loc_we    <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (loc_ack || timeout) begin
            rd_reg  <= loc_ack ? loc_rdata : 8'hFF;
            bus_err <= !loc_ack;
            rdy_n   <= 1'b0;
            AD_oe   <= 1'b1;
            state   <= RD_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WR_REQ: begin
          if (loc_ack || timeout) begin
            bus_err <= !loc_ack;
            rdy_n   <= 1'b0;
            state   <= WR_RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_RESP, WR_RESP: state <= IDLE;
        default:          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsb8_target.sv
// Directed bench for fsb8_target: a 24-bit instance and a PAE (32-bit) instance share all host-side stimulus.
module tb_fsb8_target;

  logic        clk;
  logic        rst;
  logic        ale_n, cs_n, cmd_n, wr_n, typ;
  logic [7:0]  AAH8, AD_in, loc_rdata, irq_src;
  logic        loc_ack;

  logic [7:0]  AD_out, loc_wdata;
  logic        AD_oe, rdy_n, irq_n, loc_re, loc_we, bus_err;
  logic [23:0] loc_addr;

  logic [7:0]  p_AD_out, p_loc_wdata;
  logic        p_AD_oe, p_rdy_n, p_irq_n, p_loc_re, p_loc_we, p_bus_err;
  logic [31:0] p_loc_addr;

  int total = 0;
  int bad   = 0;

  fsb8_target dut (
    .clk(clk), .rst(rst), .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .wr_n(wr_n), .typ(typ),
    .AAH8(AAH8), .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe), .rdy_n(rdy_n), .irq_n(irq_n),
    .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_re(loc_re), .loc_we(loc_we),
    .loc_rdata(loc_rdata), .loc_ack(loc_ack), .irq_src(irq_src), .bus_err(bus_err)
  );

  fsb8_target #(.PAE_ENABLE(1'b1)) dut_p (
    .clk(clk), .rst(rst), .ale_n(ale_n), .cs_n(cs_n), .cmd_n(cmd_n), .wr_n(wr_n), .typ(typ),
    .AAH8(AAH8), .AD_in(AD_in), .AD_out(p_AD_out), .AD_oe(p_AD_oe), .rdy_n(p_rdy_n), .irq_n(p_irq_n),
    .loc_addr(p_loc_addr), .loc_wdata(p_loc_wdata), .loc_re(p_loc_re), .loc_we(p_loc_we),
    .loc_rdata(loc_rdata), .loc_ack(loc_ack), .irq_src(irq_src), .bus_err(p_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [7:0] d);
    cmd_n = 1'b0; AD_in = c; AAH8 = d;
    tick();
    cmd_n = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ale_n = 1'b1; cs_n = 1'b1; cmd_n = 1'b1; wr_n = 1'b1; typ = 1'b0;
    AAH8 = 8'h00; AD_in = 8'h00; loc_rdata = 8'h00; loc_ack = 1'b0; irq_src = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    total++; if (rdy_n !== 1'b1) begin bad++; $display("FAIL reset_rdy_n: got %b want 1", rdy_n); end
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    total++; if (AD_oe !== 1'b0) begin bad++; $display("FAIL reset_ad_oe: got %b want 0", AD_oe); end
    total++; if (AD_out !== 8'h00) begin bad++; $display("FAIL reset_ad_out: got %h want 00", AD_out); end
    total++; if ({loc_re, loc_we, bus_err} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {loc_re, loc_we, bus_err}); end
    total++; if (loc_addr !== 24'h0) begin bad++; $display("FAIL reset_loc_addr: got %h want 000000", loc_addr); end
    total++; if (p_loc_addr !== 32'h0) begin bad++; $display("FAIL reset_p_loc_addr: got %h want 00000000", p_loc_addr); end
  endtask

  task automatic test_read;
    ale_n = 1'b0; AAH8 = 8'h12; AD_in = 8'h34;
    tick();
    ale_n = 1'b1; cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'h56; loc_ack = 1'b1; loc_rdata = 8'hA5;
    tick();
    total++; if (loc_re !== 1'b1) begin bad++; $display("FAIL read_loc_re: got %b want 1", loc_re); end
    total++; if (loc_addr !== 24'h123456) begin bad++; $display("FAIL read_loc_addr: got %h want 123456", loc_addr); end
    total++; if (rdy_n !== 1'b1) begin bad++; $display("FAIL read_rdy_early: got %b want 1", rdy_n); end
    tick();
    total++; if (rdy_n !== 1'b0) begin bad++; $display("FAIL read_rdy_n: got %b want 0", rdy_n); end
    total++; if (AD_oe !== 1'b1) begin bad++; $display("FAIL read_ad_oe: got %b want 1", AD_oe); end
    total++; if (AD_out !== 8'hA5) begin bad++; $display("FAIL read_ad_out: got %h want a5", AD_out); end
    total++; if (loc_re !== 1'b0) begin bad++; $display("FAIL read_re_single: got %b want 0", loc_re); end
    total++; if (loc_addr !== 24'h123456) begin bad++; $display("FAIL read_addr_stable: got %h want 123456", loc_addr); end
    total++; if (p_loc_addr !== 32'h00123456) begin bad++; $display("FAIL read_p_addr: got %h want 00123456", p_loc_addr); end
    cs_n = 1'b1; loc_ack = 1'b0;
    tick();
    total++; if ({rdy_n, AD_oe} !== 2'b10) begin bad++; $display("FAIL read_release: got rdy_n/oe %b want 10", {rdy_n, AD_oe}); end
  endtask

  task automatic test_write;
    int we_cnt = 0, rdy_cnt = 0, rdy_at = -1;
    logic [7:0] wd = 8'h00;
    cs_n = 1'b0; wr_n = 1'b0; AAH8 = 8'h07; AD_in = 8'h3C; loc_ack = 1'b0;
    tick();
    for (int k = 1; k <= 9; k++) begin
      if (loc_we) begin we_cnt++; wd = loc_wdata; end
      if (!rdy_n) begin
        rdy_cnt++;
        if (rdy_at < 0) rdy_at = k;
        cs_n = 1'b1; wr_n = 1'b1;
      end
      loc_ack = (k == 4);
      tick();
    end
    total++; if (we_cnt != 1) begin bad++; $display("FAIL write_we_pulses: got %0d want 1", we_cnt); end
    total++; if (wd !== 8'h3C) begin bad++; $display("FAIL write_wdata: got %h want 3c", wd); end
    total++; if (rdy_at != 5) begin bad++; $display("FAIL write_rdy_cycle: got %0d want 5", rdy_at); end
    total++; if (rdy_cnt != 1) begin bad++; $display("FAIL write_rdy_count: got %0d want 1", rdy_cnt); end
    total++; if (loc_addr !== 24'h123407) begin bad++; $display("FAIL write_loc_addr: got %h want 123407", loc_addr); end
  endtask

  task automatic test_timeout;
    int rdy_cnt = 0, rdy_at = -1, be_cnt = 0, be_at = -1, re_extra = 0;
    logic [7:0] dout = 8'h00;
    logic oe = 1'b0;
    cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'h99; loc_ack = 1'b0;
    tick();
    for (int k = 1; k <= 24; k++) begin
      if (!rdy_n) begin rdy_cnt++; rdy_at = k; dout = AD_out; oe = AD_oe; cs_n = 1'b1; end
      if (bus_err) begin be_cnt++; be_at = k; end
      if (loc_re && k > 1) re_extra++;
      loc_ack = (k >= 18 && k <= 20);
      tick();
    end
    loc_ack = 1'b0;
    total++; if (rdy_at != 17) begin bad++; $display("FAIL timeout_rdy_cycle: got %0d want 17", rdy_at); end
    total++; if (rdy_cnt != 1) begin bad++; $display("FAIL timeout_rdy_count: got %0d want 1", rdy_cnt); end
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL timeout_data: got %h want ff", dout); end
    total++; if (oe !== 1'b1) begin bad++; $display("FAIL timeout_oe: got %b want 1", oe); end
    total++; if (be_cnt != 1 || be_at != 17) begin bad++; $display("FAIL timeout_bus_err: got count %0d at %0d want 1 at 17", be_cnt, be_at); end
    total++; if (re_extra != 0) begin bad++; $display("FAIL timeout_late_ack: got %0d extra loc_re want 0", re_extra); end
  endtask

  task automatic test_irq;
    do_cmd(8'h01, 8'h05);
    irq_src = 8'h03;
    tick();
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_one_cycle: got %b want 1", irq_n); end
    tick();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_asserted: got %b want 0", irq_n); end
    do_cmd(8'h02, 8'h01);
    tick();
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_w1c: got %b want 1", irq_n); end
    do_cmd(8'h01, 8'h02);
    tick();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_unmask_bit1: got %b want 0", irq_n); end
    do_cmd(8'h01, 8'h01);
    tick();
    total++; if (irq_n !== 1'b1) begin bad++; $display("FAIL irq_mask_bit0: got %b want 1", irq_n); end
    irq_src = 8'h02;
    tick();
    irq_src = 8'h03; cmd_n = 1'b0; AD_in = 8'h02; AAH8 = 8'h01;
    tick();
    cmd_n = 1'b1;
    tick();
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL irq_set_beats_clear: got %b want 0", irq_n); end
    irq_src = 8'h00;
  endtask

  task automatic test_pae;
    do_cmd(8'h00, 8'h9A);
    ale_n = 1'b0; AAH8 = 8'hBC; AD_in = 8'hDE;
    tick();
    ale_n = 1'b1; cs_n = 1'b0; wr_n = 1'b1; AAH8 = 8'hF0; loc_ack = 1'b1; loc_rdata = 8'h11;
    tick();
    total++; if (p_loc_addr !== 32'h9ABCDEF0) begin bad++; $display("FAIL pae_loc_addr: got %h want 9abcdef0", p_loc_addr); end
    total++; if (loc_addr !== 24'hBCDEF0) begin bad++; $display("FAIL nopae_loc_addr: got %h want bcdef0", loc_addr); end
    tick();
    total++; if ({p_rdy_n, p_AD_out} !== 9'h011) begin bad++; $display("FAIL pae_read_resp: got rdy_n=%b data=%h want 0/11", p_rdy_n, p_AD_out); end
    cs_n = 1'b1; loc_ack = 1'b0;
    tick();
    do_cmd(8'h7F, 8'h00);
    total++; if ({bus_err, p_bus_err} !== 2'b11) begin bad++; $display("FAIL badcmd_bus_err: got %b want 11", {bus_err, p_bus_err}); end
    tick();
    total++; if ({bus_err, p_bus_err} !== 2'b00) begin bad++; $display("FAIL badcmd_pulse_len: got %b want 00", {bus_err, p_bus_err}); end
    total++; if (irq_n !== 1'b0) begin bad++; $display("FAIL badcmd_irq_state: got %b want 0", irq_n); end
    total++; if (p_loc_addr !== 32'h9ABCDEF0) begin bad++; $display("FAIL badcmd_addr_state: got %h want 9abcdef0", p_loc_addr); end
  endtask

  task automatic test_burst;
    int beat = 0, resp = 0, stray = 0;
    bit fired = 1'b0;
    typ = 1'b1; cs_n = 1'b0; wr_n = 1'b1; loc_ack = 1'b1; AAH8 = 8'h00; loc_rdata = 8'hC0;
    for (int k = 0; k < 20 && !fired; k++) begin
      tick();
      if (!rdy_n) begin
        total++; if (AD_out !== 8'(8'hC0 + beat)) begin bad++; $display("FAIL burst_data_%0d: got %h want %h", beat, AD_out, 8'(8'hC0 + beat)); end
        total++; if (loc_addr[7:0] !== 8'(beat)) begin bad++; $display("FAIL burst_addr_%0d: got %h want %h", beat, loc_addr[7:0], 8'(beat)); end
        resp++; beat++;
        AAH8 = 8'(beat); loc_rdata = 8'(8'hC0 + beat);
      end else if (loc_re && resp == 2) begin
        rst = 1'b1; cs_n = 1'b1; typ = 1'b0; fired = 1'b1;
      end
    end
    tick(); tick();
    rst = 1'b0; loc_ack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!rdy_n || loc_re || AD_oe || bus_err) stray++;
    end
    total++; if (fired !== 1'b1 || resp != 2) begin bad++; $display("FAIL burst_beats: got fired=%b resp=%0d want 1/2", fired, resp); end
    total++; if (stray != 0) begin bad++; $display("FAIL burst_stray_after_reset: got %0d want 0", stray); end
    total++; if (loc_addr !== 24'h0 || p_loc_addr !== 32'h0) begin bad++; $display("FAIL burst_reset_addr: got %h/%h want 0/0", loc_addr, p_loc_addr); end
    total++; if ({rdy_n, irq_n, AD_out} !== 10'h300) begin bad++; $display("FAIL burst_reset_outs: got rdy_n=%b irq_n=%b out=%h want 1/1/00", rdy_n, irq_n, AD_out); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_irq();
    test_pae();
    test_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
